grant_bus_sequencer: RTL and testbench
======================================

GRANT_BUS_SEQUENCER -- requirements
Module: grant_bus_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 8'd15: WAIT_ACK cycles allowed before abandoning a grant.
REQ-002 SHALL have parameter MAX_HOLD, default 8'd255: OWN cycles allowed before ownership is forcibly dropped.
REQ-003 SHALL have port Clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port GrtId, input, 3: granted requester ID from the upstream arbiter; 3'h0 means no requester.
REQ-006 SHALL have port GrtLd, input, 1: one-cycle strobe qualifying GrtId.
REQ-007 SHALL have port Ack, input, 8: per-device bus-in-use; bit n belongs to device n.
REQ-008 SHALL have port GntOH, output, 8: one-hot bus grant to the device; all zero when no device owns the bus.
REQ-009 SHALL have port Owner, output, 3: latched ID of the current grantee; 3'h0 when idle.
REQ-010 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port Done, output, 1: one-cycle pulse when a grant cycle ends.
REQ-012 SHALL have port TimeoutErr, output, 1: one-cycle pulse, coincident with Done, when an ack timeout ended the cycle.
REQ-013 SHALL have port HoldErr, output, 1: one-cycle pulse, coincident with Done, when MAX_HOLD ended the cycle.
REQ-014 SHALL have port Overrun, output, 1: one-cycle pulse when a pending grant is overwritten.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, WAIT_ACK, OWN and RELEASE; all outputs SHALL decode from the state and registers only.
REQ-016 IDLE: GntOH=0 and Owner=0; GrtLd=1 with GrtId!=0 latches GrtId into the owner register, clears Cnt and goes to WAIT_ACK; GrtLd with GrtId=0 SHALL be ignored.
REQ-017 WAIT_ACK: GntOH=onehot(owner).
REQ-018 WAIT_ACK transitions, in priority order:
- Ack[owner]=1 goes to OWN and clears Cnt.
- Cnt==ACK_TIMEOUT goes to RELEASE and sets the timeout flag.
- Otherwise Cnt increments.
REQ-019 OWN: GntOH=onehot(owner).
REQ-020 OWN transitions, in priority order:
- Ack[owner]=0 goes to RELEASE.
- Cnt==MAX_HOLD goes to RELEASE and sets the hold flag.
- Otherwise Cnt increments.
REQ-021 RELEASE SHALL last exactly one cycle, with GntOH=0, Done=1, and TimeoutErr/HoldErr set from the flags.
REQ-022 RELEASE exit:
- If a pending entry is valid: load it as the new owner, invalidate it, clear Cnt and the flags, and go to WAIT_ACK.
- Otherwise: clear the flags and go to IDLE.
REQ-023 Pending slot (single entry, 3-bit ID plus valid bit):
- GrtLd with GrtId!=0 outside IDLE writes the slot.
- Writing a slot that is already valid overwrites it and pulses Overrun.
- GrtId equal to the current owner SHALL still be queued.
REQ-024 GrtLd in the RELEASE cycle SHALL be written to the slot before the exit decision and SHALL therefore be served next.
REQ-025 Cnt SHALL be 8 bits, SHALL saturate at 8'hFF and never wrap; MAX_HOLD=255 therefore drops ownership at Cnt==255.
REQ-026 Ack bits other than Ack[owner] SHALL be ignored in every state; GntOH SHALL never have more than one bit set.
REQ-027 Latency:
- GrtLd sampled at edge k gives GntOH valid from edge k.
- Ack drop sampled at edge j gives GntOH=0 from edge j.
- The earliest new grant is at edge j+1.
REQ-028 An ack asserted and dropped within WAIT_ACK before being sampled SHALL be treated as never seen.

Reset
REQ-029 Rst=1 SHALL asynchronously force:
- State to IDLE.
- Cnt, the owner register and the pending slot to 0, and both flags to 0.
- GntOH=0, Owner=0, Busy=0, Done=0, TimeoutErr=0, HoldErr=0, Overrun=0.
REQ-030 Rst asserted mid-grant SHALL drop GntOH immediately and discard the pending entry, with no Done pulse.
REQ-031 After Rst deasserts, the block SHALL accept a GrtLd on the first clock edge.

Verification
REQ-032 Normal grant: GrtLd with GrtId=3.
- Ack[3] rises 2 cycles later and falls after 10 cycles.
- Required: GntOH=8'h08, Owner=3 for the whole grant.
- Required: one Done pulse with TimeoutErr=0, then IDLE.
REQ-033 Ack timeout: GrtId=5 with Ack held at 0.
- Required: GntOH=8'h20 for 16 cycles (Cnt 0..15).
- Then one RELEASE cycle with Done=1 and TimeoutErr=1.
REQ-034 Hold limit: GrtId=1 with Ack[1] stuck at 1.
- Required: RELEASE after 256 OWN cycles, with HoldErr=1 and Done=1.
REQ-035 Back-to-back grants: grant 2 in OWN, then GrtLd 6, then GrtLd 7 before Ack[2] falls.
- Required: Overrun pulses once.
- Required: after RELEASE, GntOH=8'h80 (ID 7 served, ID 6 lost).
REQ-036 Reset mid-OWN: assert Rst while GntOH=8'h04.
- Required: GntOH=0 without waiting for a clock edge, Done stays 0, and the pending slot is empty after release.
REQ-037 Ignored inputs: GrtLd with GrtId=0 in IDLE, and Ack[4] toggling while the owner is 2.
- Required: no state change on either stimulus, and GntOH stays one-hot or zero.

Source files
------------

// File: rtl/grant_bus_sequencer_if.sv
// Handshake bundle between the upstream arbiter, the bus devices and the grant sequencer.
// The sequencer takes the slave side; whoever drives grants and acks takes the master side.
interface grant_bus_sequencer_if;
   logic [2:0] GrtId;
   logic       GrtLd;
   logic [7:0] Ack;
   logic [7:0] GntOH;
   logic [2:0] Owner;
   logic       Busy;
   logic       Done;
   logic       TimeoutErr;
   logic       HoldErr;
   logic       Overrun;

   modport master (
      output GrtId, GrtLd, Ack,
      input  GntOH, Owner, Busy, Done, TimeoutErr, HoldErr, Overrun
   );

   modport slave (
      input  GrtId, GrtLd, Ack,
      output GntOH, Owner, Busy, Done, TimeoutErr, HoldErr, Overrun
   );
endinterface

// File: rtl/grant_bus_sequencer.sv
// Turns arbiter grant strobes into a one-hot bus grant.
// It tracks device acks, applies ack-timeout and hold limits, and keeps one pending grant queued.
module grant_bus_sequencer #(
   parameter logic [7:0] ACK_TIMEOUT = 8'd15,
   parameter logic [7:0] MAX_HOLD    = 8'd255
) (
   input logic                  Clk,
   input logic                  Rst,
   grant_bus_sequencer_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StWaitAck, StOwn, StRelease} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] owner_q, owner_d;
   logic       pend_vld_q, pend_vld_d;
   logic [2:0] pend_id_q, pend_id_d;
   logic       tflag_q, tflag_d;
   logic       hflag_q, hflag_d;
   logic       overrun_q, overrun_d;
   logic [7:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       terr_q, terr_d;
   logic       herr_q, herr_d;

   logic       ld_ok;
   logic       own_ack;
   logic [7:0] cnt_inc;

   assign ld_ok   = bus_io.GrtLd && (bus_io.GrtId != 3'h0);
   assign own_ack = bus_io.Ack[owner_q];
   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      pend_vld_d = pend_vld_q;
      pend_id_d  = pend_id_q;
      tflag_d    = tflag_q;
      hflag_d    = hflag_q;
      overrun_d  = 1'b0;

      // Queue writes land first so a strobe in the release cycle is served next.
      if (ld_ok && (state_q != StIdle)) begin
         pend_vld_d = 1'b1;
         pend_id_d  = bus_io.GrtId;
         overrun_d  = pend_vld_q;
      end

      unique case (state_q)
         StIdle: begin
            if (ld_ok) begin
               owner_d = bus_io.GrtId;
               cnt_d   = 8'd0;
               state_d = StWaitAck;
            end
         end
         StWaitAck: begin
            if (own_ack) begin
               cnt_d   = 8'd0;
               state_d = StOwn;
            end else if (cnt_q == ACK_TIMEOUT) begin
               tflag_d = 1'b1;
               state_d = StRelease;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StOwn: begin
            if (!own_ack) begin
               state_d = StRelease;
            end else if (cnt_q == MAX_HOLD) begin
               hflag_d = 1'b1;
               state_d = StRelease;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRelease: begin
            tflag_d = 1'b0;
            hflag_d = 1'b0;
            if (pend_vld_d) begin
               owner_d    = pend_id_d;
               pend_vld_d = 1'b0;
               pend_id_d  = 3'h0;
               cnt_d      = 8'd0;
               state_d    = StWaitAck;
            end else begin
               owner_d = 3'h0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are the decode of the next state, registered so they track state_q exactly.
   always_comb begin
      gnt_d  = ((state_d == StWaitAck) || (state_d == StOwn)) ? (8'd1 << owner_d) : 8'd0;
      busy_d = (state_d != StIdle);
      done_d = (state_d == StRelease);
      terr_d = (state_d == StRelease) && tflag_d;
      herr_d = (state_d == StRelease) && hflag_d;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         owner_q    <= 3'h0;
         pend_vld_q <= 1'b0;
         pend_id_q  <= 3'h0;
         tflag_q    <= 1'b0;
         hflag_q    <= 1'b0;
         overrun_q  <= 1'b0;
         gnt_q      <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
         herr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         pend_vld_q <= pend_vld_d;
         pend_id_q  <= pend_id_d;
         tflag_q    <= tflag_d;
         hflag_q    <= hflag_d;
         overrun_q  <= overrun_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         terr_q     <= terr_d;
         herr_q     <= herr_d;
      end
   end

   assign bus_io.GntOH      = gnt_q;
   assign bus_io.Owner      = owner_q;
   assign bus_io.Busy       = busy_q;
   assign bus_io.Done       = done_q;
   assign bus_io.TimeoutErr = terr_q;
   assign bus_io.HoldErr    = herr_q;
   assign bus_io.Overrun    = overrun_q;

endmodule

// File: tb/tb_grant_bus_sequencer.sv
// Directed bench for grant_bus_sequencer: normal grant, ack timeout, hold limit, queueing,
// reset mid-grant and ignored inputs, each with hand-computed expectations.
module tb_grant_bus_sequencer;

   logic Clk;
   logic Rst;
   int   checks;
   int   errors;

   grant_bus_sequencer_if bus_if ();

   grant_bus_sequencer #(
      .ACK_TIMEOUT(8'd15),
      .MAX_HOLD   (8'd255)
   ) dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .bus_io(bus_if.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (bus_if.GntOH !== 8'h00) begin errors++; $display("FAIL rst_gnt got %h want 00", bus_if.GntOH); end
      checks++; if (bus_if.Owner !== 3'h0) begin errors++; $display("FAIL rst_owner got %h want 0", bus_if.Owner); end
      checks++; if ({bus_if.Busy, bus_if.Done, bus_if.TimeoutErr, bus_if.HoldErr, bus_if.Overrun} !== 5'b0) begin
         errors++; $display("FAIL rst_flags got %b want 00000",
                            {bus_if.Busy, bus_if.Done, bus_if.TimeoutErr, bus_if.HoldErr, bus_if.Overrun});
      end
      tick();
      tick();
      checks++; if (bus_if.Busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b want 0", bus_if.Busy); end
      #3 Rst = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      bus_if.GrtId = 3'd3; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      checks++; if (bus_if.GntOH !== 8'h08) begin errors++; $display("FAIL norm_gnt got %h want 08", bus_if.GntOH); end
      checks++; if (bus_if.Owner !== 3'd3) begin errors++; $display("FAIL norm_owner got %h want 3", bus_if.Owner); end
      checks++; if (bus_if.Busy !== 1'b1) begin errors++; $display("FAIL norm_busy got %b want 1", bus_if.Busy); end
      tick();
      tick();
      bus_if.Ack = 8'h08;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus_if.GntOH !== 8'h08 || bus_if.Owner !== 3'd3 || bus_if.Done !== 1'b0) begin
            errors++; $display("FAIL norm_own%0d got gnt=%h owner=%h done=%b want 08/3/0",
                               i, bus_if.GntOH, bus_if.Owner, bus_if.Done);
         end
      end
      bus_if.Ack = 8'h00;
      tick();
      checks++; if (bus_if.Done !== 1'b1) begin errors++; $display("FAIL norm_done got %b want 1", bus_if.Done); end
      checks++; if (bus_if.TimeoutErr !== 1'b0) begin errors++; $display("FAIL norm_terr got %b want 0", bus_if.TimeoutErr); end
      checks++; if (bus_if.GntOH !== 8'h00) begin errors++; $display("FAIL norm_rel_gnt got %h want 00", bus_if.GntOH); end
      tick();
      checks++; if ({bus_if.Busy, bus_if.Done, bus_if.Owner} !== 5'b0) begin
         errors++; $display("FAIL norm_idle got busy=%b done=%b owner=%h want 0/0/0", bus_if.Busy, bus_if.Done, bus_if.Owner);
      end
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      bus_if.GrtId = 3'd5; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      for (int i = 0; i < 40 && bus_if.GntOH === 8'h20; i++) begin
         n++;
         tick();
      end
      checks++; if (n != 16) begin errors++; $display("FAIL tmo_cycles got %0d want 16", n); end
      checks++; if (bus_if.Done !== 1'b1) begin errors++; $display("FAIL tmo_done got %b want 1", bus_if.Done); end
      checks++; if (bus_if.TimeoutErr !== 1'b1) begin errors++; $display("FAIL tmo_terr got %b want 1", bus_if.TimeoutErr); end
      checks++; if (bus_if.HoldErr !== 1'b0) begin errors++; $display("FAIL tmo_herr got %b want 0", bus_if.HoldErr); end
      tick();
      checks++; if ({bus_if.Busy, bus_if.Done, bus_if.TimeoutErr} !== 3'b0) begin
         errors++; $display("FAIL tmo_idle got %b want 000", {bus_if.Busy, bus_if.Done, bus_if.TimeoutErr});
      end
   endtask

   task automatic test_hold();
      int n;
      n = 0;
      bus_if.Ack = 8'h02;
      bus_if.GrtId = 3'd1; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      // One WAIT_ACK cycle plus 256 OWN cycles (Cnt 0..255).
      for (int i = 0; i < 400 && bus_if.GntOH === 8'h02; i++) begin
         n++;
         tick();
      end
      checks++; if (n != 257) begin errors++; $display("FAIL hold_cycles got %0d want 257", n); end
      checks++; if (bus_if.Done !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", bus_if.Done); end
      checks++; if (bus_if.HoldErr !== 1'b1) begin errors++; $display("FAIL hold_herr got %b want 1", bus_if.HoldErr); end
      checks++; if (bus_if.TimeoutErr !== 1'b0) begin errors++; $display("FAIL hold_terr got %b want 0", bus_if.TimeoutErr); end
      bus_if.Ack = 8'h00;
      tick();
      checks++; if ({bus_if.Busy, bus_if.HoldErr} !== 2'b0) begin
         errors++; $display("FAIL hold_idle got %b want 00", {bus_if.Busy, bus_if.HoldErr});
      end
   endtask

   task automatic test_back_to_back();
      bus_if.GrtId = 3'd2; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0;
      bus_if.Ack = 8'h04;
      tick();
      bus_if.GrtLd = 1'b1; bus_if.GrtId = 3'd6;
      tick();
      checks++; if (bus_if.Overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr_first got %b want 0", bus_if.Overrun); end
      bus_if.GrtId = 3'd7;
      tick();
      checks++; if (bus_if.Overrun !== 1'b1) begin errors++; $display("FAIL b2b_ovr_second got %b want 1", bus_if.Overrun); end
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      tick();
      checks++; if (bus_if.Overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr_pulse got %b want 0", bus_if.Overrun); end
      checks++; if (bus_if.GntOH !== 8'h04) begin errors++; $display("FAIL b2b_gnt2 got %h want 04", bus_if.GntOH); end
      bus_if.Ack = 8'h00;
      tick();
      checks++; if (bus_if.Done !== 1'b1 || bus_if.GntOH !== 8'h00) begin
         errors++; $display("FAIL b2b_release got done=%b gnt=%h want 1/00", bus_if.Done, bus_if.GntOH);
      end
      tick();
      checks++; if (bus_if.GntOH !== 8'h80) begin errors++; $display("FAIL b2b_gnt7 got %h want 80", bus_if.GntOH); end
      checks++; if (bus_if.Owner !== 3'd7) begin errors++; $display("FAIL b2b_owner7 got %h want 7", bus_if.Owner); end
      bus_if.Ack = 8'h80;
      tick();
      bus_if.Ack = 8'h00;
      tick();
      checks++; if (bus_if.Done !== 1'b1) begin errors++; $display("FAIL b2b_done7 got %b want 1", bus_if.Done); end
      tick();
      checks++; if (bus_if.Busy !== 1'b0) begin errors++; $display("FAIL b2b_id6_lost got busy=%b want 0", bus_if.Busy); end
   endtask

   task automatic test_ignored();
      int n;
      n = 0;
      bus_if.GrtId = 3'd0; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0;
      checks++; if ({bus_if.Busy, bus_if.GntOH, bus_if.Owner} !== 12'h0) begin
         errors++; $display("FAIL ign_id0 got busy=%b gnt=%h owner=%h want 0/00/0", bus_if.Busy, bus_if.GntOH, bus_if.Owner);
      end
      bus_if.GrtId = 3'd2; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      // Ack[4] toggles; only Ack[2] may move the FSM, so this must end in an ack timeout.
      for (int i = 0; i < 40 && bus_if.GntOH === 8'h04; i++) begin
         n++;
         bus_if.Ack = (i % 2 == 0) ? 8'h10 : 8'h00;
         tick();
      end
      bus_if.Ack = 8'h00;
      checks++; if (n != 16) begin errors++; $display("FAIL ign_ack4_cycles got %0d want 16", n); end
      checks++; if (bus_if.Done !== 1'b1 || bus_if.TimeoutErr !== 1'b1) begin
         errors++; $display("FAIL ign_ack4_end got done=%b terr=%b want 1/1", bus_if.Done, bus_if.TimeoutErr);
      end
      checks++; if (!$onehot0(bus_if.GntOH)) begin errors++; $display("FAIL ign_onehot got %h want onehot0", bus_if.GntOH); end
      tick();
   endtask

   task automatic test_reset_mid();
      bus_if.GrtId = 3'd2; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0;
      bus_if.Ack = 8'h04;
      tick();
      checks++; if (bus_if.GntOH !== 8'h04) begin errors++; $display("FAIL rmid_gnt got %h want 04", bus_if.GntOH); end
      bus_if.GrtLd = 1'b1; bus_if.GrtId = 3'd6;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      #2 Rst = 1'b1;
      #1;
      checks++; if (bus_if.GntOH !== 8'h00) begin errors++; $display("FAIL rmid_async_gnt got %h want 00", bus_if.GntOH); end
      checks++; if ({bus_if.Busy, bus_if.Done, bus_if.Owner} !== 5'b0) begin
         errors++; $display("FAIL rmid_async_state got busy=%b done=%b owner=%h want 0/0/0",
                            bus_if.Busy, bus_if.Done, bus_if.Owner);
      end
      bus_if.Ack = 8'h00;
      #2 Rst = 1'b0;
      bus_if.GrtId = 3'd4; bus_if.GrtLd = 1'b1;
      tick();
      bus_if.GrtLd = 1'b0; bus_if.GrtId = 3'd0;
      checks++; if (bus_if.GntOH !== 8'h10) begin errors++; $display("FAIL rmid_first_edge got %h want 10", bus_if.GntOH); end
      bus_if.Ack = 8'h10;
      tick();
      bus_if.Ack = 8'h00;
      tick();
      checks++; if (bus_if.Done !== 1'b1) begin errors++; $display("FAIL rmid_done got %b want 1", bus_if.Done); end
      tick();
      checks++; if (bus_if.Busy !== 1'b0 || bus_if.GntOH !== 8'h00) begin
         errors++; $display("FAIL rmid_pend_empty got busy=%b gnt=%h want 0/00", bus_if.Busy, bus_if.GntOH);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Rst = 1'b1;
      bus_if.GrtId = 3'd0;
      bus_if.GrtLd = 1'b0;
      bus_if.Ack   = 8'h00;
      test_reset();
      test_normal();
      test_timeout();
      test_hold();
      test_back_to_back();
      test_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
